// File: rtl/controller_interface.sv
// Serial interface for two NES-style pads: a rising vsync starts one latch/shift fetch,
// and the button bytes are readable by the CPU at 0x7002 (pad 1) and 0x7003 (pad 2).
module controller_interface #(
  parameter int unsigned HALF = 1
) (
  input  logic        clk,
  input  logic        rst_B,
  input  logic        vsync,
  input  logic [15:0] cpu_address,
  input  logic        write_enable_B,
  output logic [7:0]  data_out,
  output logic        data_enable,
  output logic        controller_clk,
  output logic        controller_latch,
  input  logic        ctrl1_data_in_B,
  input  logic        ctrl2_data_in_B
);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  localparam int unsigned    CW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]  PH_LAST = CW'(HALF - 1);

  state_t        state, state_n;
  logic [CW-1:0] ph_cnt, ph_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          vsync_q;
  logic          trigger;
  logic          phase_end;
  logic [7:0]    sr1, sr2;
  logic [7:0]    btn1, btn2;
  logic          sel1, sel2;

  assign trigger   = vsync & ~vsync_q;
  assign phase_end = (ph_cnt == PH_LAST);

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_n;
      ph_cnt  <= ph_cnt_n;
      bit_cnt <= bit_cnt_n;
      vsync_q <= vsync;
    end
  end

  always_comb begin
    state_n          = state;
    ph_cnt_n         = ph_cnt;
    bit_cnt_n        = bit_cnt;
    controller_latch = 1'b0;
    controller_clk   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n   = LATCH;
          ph_cnt_n  = '0;
          bit_cnt_n = '0;
        end
      end
      LATCH, LOW, HIGH: begin
        controller_latch = (state == LATCH);
        controller_clk   = (state == HIGH);
        if (!phase_end) begin
          ph_cnt_n = ph_cnt + CW'(1);
        end else begin
          ph_cnt_n = '0;
          case (state)
            LATCH:   state_n = LOW;
            LOW:     state_n = HIGH;
            default: begin
              // HIGH closes a bit; after the eighth rise the byte is complete
              if (bit_cnt == 3'd7) begin
                state_n = DONE;
              end else begin
                state_n   = LOW;
                bit_cnt_n = bit_cnt + 3'd1;
              end
            end
          endcase
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      sr1  <= '0;
      sr2  <= '0;
      btn1 <= '0;
      btn2 <= '0;
    end else begin
      if (state == LOW && phase_end) begin
        sr1 <= {sr1[6:0], ~ctrl1_data_in_B};
        sr2 <= {sr2[6:0], ~ctrl2_data_in_B};
      end
      if (state == DONE) begin
        btn1 <= sr1;
        btn2 <= sr2;
      end
    end
  end

  assign sel1        = write_enable_B & (cpu_address == 16'h7002);
  assign sel2        = write_enable_B & (cpu_address == 16'h7003);
  assign data_enable = sel1 | sel2;

  always_comb begin
    data_out = '0;
    if (sel1)      data_out = btn1;
    else if (sel2) data_out = btn2;
  end

endmodule

// File: tb/tb_controller_interface.sv
// Bench for controller_interface: two instances (short and long half-phase) driven by
// behavioural pad models, checked against a frame-level model of expected button bytes.
module tb_controller_interface;

  localparam int unsigned HA   = 1;
  localparam int unsigned HB   = 3;
  localparam int unsigned FULL = 17 * HB + 3;

  logic        clk = 1'b0;
  logic        rst_B;
  logic        vsync;
  logic        write_enable_B;
  logic [15:0] cpu_address;
  logic [7:0]  pad1, pad2;

  logic [7:0]  dout [2];
  logic        den  [2];
  logic        cclk [2];
  logic        clat [2];
  logic        d1   [2];
  logic        d2   [2];

  always #5 clk = ~clk;

  controller_interface #(.HALF(HA)) u_dut_a (
    .clk(clk), .rst_B(rst_B), .vsync(vsync), .cpu_address(cpu_address),
    .write_enable_B(write_enable_B), .data_out(dout[0]), .data_enable(den[0]),
    .controller_clk(cclk[0]), .controller_latch(clat[0]),
    .ctrl1_data_in_B(d1[0]), .ctrl2_data_in_B(d2[0])
  );

  controller_interface #(.HALF(HB)) u_dut_b (
    .clk(clk), .rst_B(rst_B), .vsync(vsync), .cpu_address(cpu_address),
    .write_enable_B(write_enable_B), .data_out(dout[1]), .data_enable(den[1]),
    .controller_clk(cclk[1]), .controller_latch(clat[1]),
    .ctrl1_data_in_B(d1[1]), .ctrl2_data_in_B(d2[1])
  );

  // Pads: load buttons on latch, present bit 7 first, shift on each clk rise
  for (genvar g = 0; g < 2; g++) begin : g_pad
    logic [7:0] q1, q2;
    always @(posedge clat[g] or posedge cclk[g]) begin
      if (clat[g]) begin
        q1 <= pad1;
        q2 <= pad2;
      end else begin
        q1 <= {q1[6:0], 1'b0};
        q2 <= {q2[6:0], 1'b0};
      end
    end
    assign d1[g] = ~q1[7];
    assign d2[g] = ~q2[7];
  end

  // Frame-level model: a vsync rise while idle captures the pads; the bytes become
  // readable 17*HALF+1 edges later. Edges up to and including that one count as busy.
  int unsigned cyc;
  logic        vs_prev;
  int unsigned busy_end [2];
  logic [7:0]  exp1 [2], exp2 [2], pend1 [2], pend2 [2];

  always @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      cyc     <= 0;
      vs_prev <= 1'b0;
      for (int g = 0; g < 2; g++) begin
        busy_end[g] <= 0;
        exp1[g]     <= 8'h00;
        exp2[g]     <= 8'h00;
        pend1[g]    <= 8'h00;
        pend2[g]    <= 8'h00;
      end
    end else begin
      cyc     <= cyc + 1;
      vs_prev <= vsync;
      for (int g = 0; g < 2; g++) begin
        if (cyc + 1 == busy_end[g]) begin
          exp1[g] <= pend1[g];
          exp2[g] <= pend2[g];
        end
        if (vsync && !vs_prev && (cyc + 1 > busy_end[g])) begin
          busy_end[g] <= cyc + 1 + 17 * ((g == 0) ? HA : HB) + 1;
          pend1[g]    <= pad1;
          pend2[g]    <= pad2;
        end
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, want);
    end
  endtask

  int unsigned lat_cyc [2], clk_hi [2], clk_rise [2];
  logic        cclk_prev [2];

  task automatic clear_mon();
    for (int g = 0; g < 2; g++) begin
      lat_cyc[g] = 0; clk_hi[g] = 0; clk_rise[g] = 0; cclk_prev[g] = 1'b0;
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (clat[g]) lat_cyc[g]++;
        if (cclk[g]) clk_hi[g]++;
        if (cclk[g] && !cclk_prev[g]) clk_rise[g]++;
        cclk_prev[g] = cclk[g];
      end
    end
  endtask

  task automatic vs_pulse(input int unsigned len);
    vsync = 1'b1;
    step(len);
    vsync = 1'b0;
  endtask

  task automatic read_all(input string tag);
    write_enable_B = 1'b1;
    cpu_address = 16'h7002;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_i%0d_pad1", tag, g), dout[g], exp1[g]);
      check($sformatf("%s_i%0d_en1", tag, g), {7'b0, den[g]}, 8'h01);
    end
    cpu_address = 16'h7003;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_i%0d_pad2", tag, g), dout[g], exp2[g]);
      check($sformatf("%s_i%0d_en2", tag, g), {7'b0, den[g]}, 8'h01);
    end
    cpu_address = 16'h0000;
  endtask

  task automatic check_wave(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_i%0d_latch_cyc", tag, g), 8'(lat_cyc[g]), 8'((g == 0) ? HA : HB));
      check($sformatf("%s_i%0d_clk_rise", tag, g), 8'(clk_rise[g]), 8'd8);
      check($sformatf("%s_i%0d_clk_hi", tag, g), 8'(clk_hi[g]), 8'(8 * ((g == 0) ? HA : HB)));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_i%0d_clk", tag, g), {7'b0, cclk[g]}, 8'h00);
      check($sformatf("%s_i%0d_latch", tag, g), {7'b0, clat[g]}, 8'h00);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic        rd;
    logic [15:0] dec_addr [4];
    dec_addr = '{16'h7001, 16'h7004, 16'h7003, 16'h7002};

    rst_B = 1'b0; vsync = 1'b0; write_enable_B = 1'b1; cpu_address = 16'h0000;
    pad1 = 8'h00; pad2 = 8'h00;
    clear_mon();
    step(3);
    check_idle_outputs("reset");
    for (int g = 0; g < 2; g++) check($sformatf("reset_i%0d_den", g), {7'b0, den[g]}, 8'h00);
    rst_B = 1'b1;
    step(2);
    read_all("after_reset");

    // First fetch; vsync stays high well past the end to show no retrigger
    pad1 = 8'h88; pad2 = 8'h26;
    clear_mon();
    vsync = 1'b1;
    step(17 * HA + 2);
    read_all("fetch1_short_done");
    step(FULL + 10);
    read_all("fetch1_all_done");
    check_wave("fetch1_wave");
    vsync = 1'b0;
    step(2);

    // Pads change and vsync re-pulses during a fetch
    clear_mon();
    vs_pulse(1);
    step(5);
    pad1 = 8'hFF; pad2 = 8'h01;
    vs_pulse(2);
    step(3);
    read_all("mid_fetch_old");
    step(FULL);
    read_all("ignored_edge");
    check_wave("ignored_wave");
    vs_pulse(1);
    step(FULL);
    read_all("clean_edge");
    for (int g = 0; g < 2; g++) begin
      check($sformatf("clean_edge_i%0d_exp1", g), exp1[g], 8'hFF);
    end

    // Read decode, including write cycles and neighbouring addresses
    for (int i = 0; i < 28; i++) begin
      if (i < 4) begin
        a  = dec_addr[i];
        rd = (i == 3);
      end else begin
        a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h7000 + 16'($urandom_range(0, 5));
        rd = 1'($urandom_range(0, 1));
      end
      write_enable_B = rd;
      cpu_address    = a;
      #1;
      for (int g = 0; g < 2; g++) begin
        check($sformatf("decode_%04h_we%0d_i%0d_en", a, rd, g), {7'b0, den[g]},
              {7'b0, rd && (a == 16'h7002 || a == 16'h7003)});
        check($sformatf("decode_%04h_we%0d_i%0d_data", a, rd, g), dout[g],
              !rd ? 8'h00 : (a == 16'h7002) ? exp1[g] : (a == 16'h7003) ? exp2[g] : 8'h00);
      end
      step(1);
    end
    write_enable_B = 1'b1;
    cpu_address = 16'h0000;

    // Random pads and vsync timing
    for (int i = 0; i < 8; i++) begin
      pad1 = 8'($urandom); pad2 = 8'($urandom);
      vs_pulse($urandom_range(1, 4));
      step($urandom_range(1, 17 * HB));
      read_all($sformatf("rand%0d_mid", i));
      step(FULL);
      read_all($sformatf("rand%0d_end", i));
    end

    // Reset while bit 4 is being shifted
    pad1 = 8'h88; pad2 = 8'h26;
    vs_pulse(1);
    step(7 * HA);
    rst_B = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    read_all("reset_mid");
    step(2);
    rst_B = 1'b1;
    step(2);
    vs_pulse(1);
    step(FULL);
    read_all("after_abort");
    for (int g = 0; g < 2; g++) begin
      check($sformatf("after_abort_i%0d_exp2", g), exp2[g], 8'h26);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
